demux_lanes_param: RTL and testbench

//  Parametrised serial-to-parallel lane demultiplexer, the successor of the fixed 4-lane demux.

---
 rtl/demux_lanes_param_if.sv | 25 ++
 rtl/demux_lanes_param.sv | 85 ++++++++
 tb/tb_demux_lanes_param.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_lanes_param_if.sv
// Bus bundle for the lane demultiplexer: serial input side and parallel group output side.
interface demux_lanes_param_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
);
    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_sop;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_lane_valid;
    logic                    out_strobe;
    logic                    err_partial;

    // Producer of serial words / consumer of presented groups.
    modport master (
        output in_data, in_valid, in_sop,
        input  out_data, out_lane_valid, out_strobe, err_partial
    );

    // The demultiplexer itself.
    modport slave (
        input  in_data, in_valid, in_sop,
        output out_data, out_lane_valid, out_strobe, err_partial
    );
endinterface

// File: rtl/demux_lanes_param.sv
// Serial-to-parallel lane demultiplexer: consecutive valid words fill lanes 0..LANES-1
// round-robin; a completed (or flushed partial) group is presented with a one-cycle strobe.
module demux_lanes_param #(
    parameter int DATA_W       = 8,
    parameter int LANES        = 4,
    parameter bit DROP_PARTIAL = 1'b0
) (
    input logic               clk,
    input logic               reset_L,
    demux_lanes_param_if.slave bus
);
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    logic [CNT_W-1:0]        cnt;
    logic [LANES*DATA_W-1:0] stage_data;
    logic [LANES-1:0]        stage_mask;
    logic [LANES*DATA_W-1:0] stage_ins;
    logic [LANES*DATA_W-1:0] stage_flush;
    logic [LANES*DATA_W-1:0] out_data_q;
    logic [LANES-1:0]        out_lane_valid_q;
    logic                    out_strobe_q;
    logic                    err_partial_q;

    // Staging with the incoming word inserted at the current lane, and the masked partial view
    // (unfilled lanes forced to zero so stale words never leak into a flushed group).
    always_comb begin
        stage_ins   = stage_data;
        stage_flush = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (cnt == CNT_W'(k)) begin
                stage_ins[k*DATA_W +: DATA_W] = bus.in_data;
            end
            if (stage_mask[k]) begin
                stage_flush[k*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Lane counter, staging capture and group presentation.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt              <= '0;
            stage_data       <= '0;
            stage_mask       <= '0;
            out_data_q       <= '0;
            out_lane_valid_q <= '0;
            out_strobe_q     <= 1'b0;
            err_partial_q    <= 1'b0;
        end else begin
            out_strobe_q  <= 1'b0;
            err_partial_q <= 1'b0;
            if (bus.in_valid) begin
                if (bus.in_sop && cnt != '0) begin
                    // Early realign: close out the partial group, sop word restarts at lane 0.
                    err_partial_q <= 1'b1;
                    if (!DROP_PARTIAL) begin
                        out_data_q       <= stage_flush;
                        out_lane_valid_q <= stage_mask;
                        out_strobe_q     <= 1'b1;
                    end
                    stage_data[DATA_W-1:0] <= bus.in_data;
                    stage_mask             <= LANES'(1);
                    cnt                    <= CNT_W'(1);
                end else if (cnt == LAST) begin
                    out_data_q       <= stage_ins;
                    out_lane_valid_q <= '1;
                    out_strobe_q     <= 1'b1;
                    stage_data       <= stage_ins;
                    stage_mask       <= '0;
                    cnt              <= '0;
                end else begin
                    stage_data <= stage_ins;
                    stage_mask <= stage_mask | (LANES'(1) << cnt);
                    cnt        <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_data       = out_data_q;
    assign bus.out_lane_valid = out_lane_valid_q;
    assign bus.out_strobe     = out_strobe_q;
    assign bus.err_partial    = err_partial_q;
endmodule

// File: tb/tb_demux_lanes_param.sv
// Bench for demux_lanes_param: three instances (4 lanes flush, 4 lanes drop, 8 lanes x 9 bits)
// share one stimulus stream and are checked against a list-based group model.
module tb_demux_lanes_param;
    logic clk = 1'b0;
    logic reset_L = 1'b0;

    always #5 clk = ~clk;

    demux_lanes_param_if #(.DATA_W(8), .LANES(4)) if_a ();
    demux_lanes_param_if #(.DATA_W(8), .LANES(4)) if_b ();
    demux_lanes_param_if #(.DATA_W(9), .LANES(8)) if_c ();

    demux_lanes_param #(.DATA_W(8), .LANES(4), .DROP_PARTIAL(1'b0)) u_a (
        .clk(clk), .reset_L(reset_L), .bus(if_a.slave));
    demux_lanes_param #(.DATA_W(8), .LANES(4), .DROP_PARTIAL(1'b1)) u_b (
        .clk(clk), .reset_L(reset_L), .bus(if_b.slave));
    demux_lanes_param #(.DATA_W(9), .LANES(8), .DROP_PARTIAL(1'b0)) u_c (
        .clk(clk), .reset_L(reset_L), .bus(if_c.slave));

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;

    // Model: per instance, the list of words collected for the current group.
    int unsigned lanes_of [3] = '{4, 4, 8};
    int unsigned w_of     [3] = '{8, 8, 9};
    bit          drop_of  [3] = '{1'b0, 1'b1, 1'b0};
    int unsigned words    [3][8];
    int unsigned fill     [3];

    logic [71:0] exp_data   [3];
    logic [7:0]  exp_mask   [3];
    logic        exp_strobe [3];
    logic        exp_err    [3];

    logic [71:0] got_data   [3];
    logic [7:0]  got_mask   [3];
    logic        got_strobe [3];
    logic        got_err    [3];

    assign got_data[0]   = 72'(if_a.out_data);
    assign got_data[1]   = 72'(if_b.out_data);
    assign got_data[2]   = 72'(if_c.out_data);
    assign got_mask[0]   = 8'(if_a.out_lane_valid);
    assign got_mask[1]   = 8'(if_b.out_lane_valid);
    assign got_mask[2]   = 8'(if_c.out_lane_valid);
    assign got_strobe[0] = if_a.out_strobe;
    assign got_strobe[1] = if_b.out_strobe;
    assign got_strobe[2] = if_c.out_strobe;
    assign got_err[0]    = if_a.err_partial;
    assign got_err[1]    = if_b.err_partial;
    assign got_err[2]    = if_c.err_partial;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            fill[i]       = 0;
            exp_data[i]   = '0;
            exp_mask[i]   = '0;
            exp_strobe[i] = 1'b0;
            exp_err[i]    = 1'b0;
        end
    endtask

    // Present the first n collected words of instance i as a group.
    task automatic present(input int i, input int unsigned n);
        logic [71:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < n; k++) begin
            acc |= 72'(words[i][k]) << (k * w_of[i]);
        end
        exp_data[i]   = acc;
        exp_mask[i]   = 8'((1 << n) - 1);
        exp_strobe[i] = 1'b1;
    endtask

    task automatic model_step(input bit v, input bit sop, input logic [8:0] d);
        int unsigned wd;
        for (int i = 0; i < 3; i++) begin
            exp_strobe[i] = 1'b0;
            exp_err[i]    = 1'b0;
            if (v) begin
                wd = 32'(d) & ((1 << w_of[i]) - 1);
                if (sop && fill[i] != 0) begin
                    exp_err[i] = 1'b1;
                    if (!drop_of[i]) present(i, fill[i]);
                    fill[i] = 0;
                end
                words[i][fill[i]] = wd;
                fill[i]++;
                if (fill[i] == lanes_of[i]) begin
                    present(i, lanes_of[i]);
                    fill[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("strobe%0d", i), 72'(got_strobe[i]), 72'(exp_strobe[i]));
            check($sformatf("err%0d", i),    72'(got_err[i]),    72'(exp_err[i]));
            check($sformatf("mask%0d", i),   72'(got_mask[i]),   72'(exp_mask[i]));
            check($sformatf("data%0d", i),   got_data[i],        exp_data[i]);
        end
    endtask

    // One clock: drive inputs (from a negedge), model the rising edge, check at the next negedge.
    task automatic step(input bit v, input bit sop, input logic [8:0] d);
        if_a.in_valid = v; if_a.in_sop = sop; if_a.in_data = d[7:0];
        if_b.in_valid = v; if_b.in_sop = sop; if_b.in_data = d[7:0];
        if_c.in_valid = v; if_c.in_sop = sop; if_c.in_data = d;
        @(posedge clk);
        model_step(v, sop, d);
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        if_a.in_valid = 1'b0; if_a.in_sop = 1'b0; if_a.in_data = '0;
        if_b.in_valid = 1'b0; if_b.in_sop = 1'b0; if_b.in_data = '0;
        if_c.in_valid = 1'b0; if_c.in_sop = 1'b0; if_c.in_data = '0;
        reset_L = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    int strobe_cyc[$];

    initial begin
        do_reset();

        // Four consecutive words form one full group.
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 9'(k));
        check("t1_data", got_data[0], 72'h04030201);
        check("t1_mask", 72'(got_mask[0]), 72'hF);
        check("t1_strobe", 72'(got_strobe[0]), 72'h1);
        step(1'b0, 1'b0, 9'h0);
        check("t1_strobe_gone", 72'(got_strobe[0]), 72'h0);

        // Bubbles between words must not shift lanes.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 9'(k));
            if (k != 4) step(1'b0, 1'b1, 9'h1FF);
        end
        check("t2_data", got_data[0], 72'h04030201);
        check("t2_strobe", 72'(got_strobe[0]), 72'h1);

        // Early sop: flush (instance a) versus drop (instance b).
        step(1'b1, 1'b0, 9'hA1);
        step(1'b1, 1'b0, 9'hA2);
        step(1'b1, 1'b1, 9'hB0);
        check("t3_data", got_data[0], 72'h0000A2A1);
        check("t3_mask", 72'(got_mask[0]), 72'h3);
        check("t3_err", 72'(got_err[0]), 72'h1);
        check("t4_err", 72'(got_err[1]), 72'h1);
        check("t4_no_strobe", 72'(got_strobe[1]), 72'h0);
        step(1'b1, 1'b0, 9'hB1);
        step(1'b1, 1'b0, 9'hB2);
        step(1'b1, 1'b0, 9'hB3);
        check("t3_full", got_data[0], 72'hB3B2B1B0);
        check("t3_full_mask", 72'(got_mask[0]), 72'hF);
        check("t4_full", got_data[1], 72'hB3B2B1B0);

        // Reset in the middle of a group discards staged words.
        step(1'b1, 1'b0, 9'h55);
        step(1'b1, 1'b0, 9'h66);
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 9'(8'h11 + k));
        check("t5_data", got_data[0], 72'h14131211);
        check("t5_strobe", 72'(got_strobe[0]), 72'h1);

        // Eight-lane instance: 16 continuous words, strobes 8 cycles apart.
        do_reset();
        strobe_cyc.delete();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 9'(k));
            if (got_strobe[2]) strobe_cyc.push_back(int'(cyc));
        end
        check("t6_count", 72'(strobe_cyc.size()), 72'd2);
        if (strobe_cyc.size() == 2) check("t6_gap", 72'(strobe_cyc[1] - strobe_cyc[0]), 72'd8);
        check("t6_data", got_data[2],
              {9'd15, 9'd14, 9'd13, 9'd12, 9'd11, 9'd10, 9'd9, 9'd8});

        // Randomised traffic with bubbles and occasional sop.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 9'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
